// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/256 key schedule streaming round keys 0..NR under valid/ready.
// Defining AES_KEY_STORE_EN adds an (NR+1)-entry round-key store readable through rd_addr/rd_key.
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = '0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   // x^254 is the field inverse (and maps 0 to 0)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int k = 0; k < 7; k++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   logic [7:0] w_inv;
   assign w_inv  = gf_inv(i_byte);
   assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expander #(
   parameter int KEY_BITS = 128
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                busy,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        round_key,
   output logic [3:0]          rk_idx,
   output logic [7:0]          rcon_out,
   output logic                done,
   input  logic [3:0]          rd_addr,
   output logic [127:0]        rd_key
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;

   generate
      if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_key_expander: KEY_BITS must be 128 or 256");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;

   state_t              r_state;
   logic [KEY_BITS-1:0] r_win;
   logic [7:0]          r_rcon;
   logic                r_busy;
   logic                r_valid;
   logic [127:0]        r_rk;
   logic [3:0]          r_idx;
   logic [7:0]          r_rcon_out;
   logic                r_done;

   logic                    w_adv;
   logic                    w_copy;
   logic                    w_use_rcon;
   logic                    w_last;
   logic [31:0]             w_prev;
   logic [31:0]             w_sub_in;
   logic [31:0]             w_sub;
   logic [31:0]             w_t;
   logic [127:0]            w_new;
   logic [KEY_BITS+127:0]   w_cat;

   assign w_adv      = r_valid && rk_ready;
   // AES-256 round key 1 is the lower key half, already sitting in the window
   assign w_copy     = (NK == 8) && (r_idx == 4'd0);
   assign w_use_rcon = (NK == 4) || r_idx[0];
   assign w_last     = r_idx == 4'(NR);
   assign w_prev     = r_win[31:0];
   assign w_sub_in   = w_use_rcon ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_sbox
         aes_sbox u_sbox (.i_byte(w_sub_in[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
      end
   endgenerate

   assign w_t             = w_sub ^ {(w_use_rcon ? r_rcon : 8'h00), 24'h0};
   assign w_new[127:96]   = r_win[KEY_BITS-1  -: 32] ^ w_t;
   assign w_new[95:64]    = r_win[KEY_BITS-33 -: 32] ^ w_new[127:96];
   assign w_new[63:32]    = r_win[KEY_BITS-65 -: 32] ^ w_new[95:64];
   assign w_new[31:0]     = r_win[KEY_BITS-97 -: 32] ^ w_new[63:32];
   assign w_cat           = {r_win, w_new};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_win      <= '0;
         r_rcon     <= 8'h01;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_rk       <= '0;
         r_idx      <= '0;
         r_rcon_out <= 8'h00;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            if (start) begin
               r_state    <= RUN;
               r_busy     <= 1'b1;
               r_valid    <= 1'b1;
               r_win      <= key_in;
               r_rk       <= key_in[KEY_BITS-1 -: 128];
               r_idx      <= '0;
               r_rcon_out <= 8'h00;
               r_rcon     <= 8'h01;
            end
         end else if (w_adv) begin
            if (w_last) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_idx      <= r_idx + 4'd1;
               r_rk       <= w_copy ? r_win[127:0] : w_new;
               r_win      <= w_copy ? r_win : w_cat[KEY_BITS-1:0];
               r_rcon_out <= (!w_copy && w_use_rcon) ? r_rcon : 8'h00;
               if (!w_copy && w_use_rcon)
                  r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            end
         end
      end
   end

   assign busy      = r_busy;
   assign rk_valid  = r_valid;
   assign round_key = r_rk;
   assign rk_idx    = r_idx;
   assign rcon_out  = r_rcon_out;
   assign done      = r_done;

`ifdef AES_KEY_STORE_EN
   logic [127:0] r_store [0:NR];
   logic [127:0] r_rd;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k <= NR; k++) r_store[k] <= '0;
         r_rd <= '0;
      end else begin
         if (w_adv) r_store[r_idx] <= r_rk;
         r_rd <= (rd_addr <= 4'(NR)) ? r_store[rd_addr] : '0;
      end
   end

   assign rd_key = r_rd;
`else
   logic w_unused;
   assign w_unused = ^rd_addr;
   assign rd_key   = '0;
`endif
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Parametrised iterative AES key schedule engine: loads a 128- or 256-bit cipher key and streams round keys 0..NR, one 128-bit round key per accepted beat, each with its round index and Rcon value. It feeds the AES round datapath and replaces fixed-width, free-running key generation with a start/valid/ready controlled engine. It contains four instances of the team's combinational byte S-box `aes_sbox` (8-bit in, 8-bit out) for SubWord.

## Interface
- KEY_BITS, 128, cipher key width; legal values 128 and 256, any other value is an elaboration error.
- NK (local), KEY_BITS/32, key length in words.
- NR (local), NK+6, last round index (10 or 14).
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  load request; sampled only while busy=0.
- key_in  input  KEY_BITS  cipher key, FIPS-197 byte order (first key byte at MSB).
- busy  output  1  high from the cycle after start is accepted until the final beat is accepted.
- rk_valid  output  1  round_key/rk_idx/rcon_out are valid.
- rk_ready  input  1  consumer accepts the current beat.
- round_key  output  128  current round key, FIPS-197 byte order.
- rk_idx  output  4  round index of round_key, 0..NR.
- rcon_out  output  8  Rcon byte used to derive round_key; 8'h00 if none.
- done  output  1  one-cycle pulse after the beat with rk_idx=NR is accepted.
- rd_addr  input  4  stored-key read index (AES_KEY_STORE_EN only).
- rd_key  output  128  stored round key (AES_KEY_STORE_EN only).

## Operation
- Reset: busy=0, rk_valid=0, done=0, round_key=0, rk_idx=0, rcon_out=8'h00, window register=0, internal rcon=8'h01, rd_key=0.
- States: IDLE, RUN. IDLE + start -> RUN, window<=key_in, rk_idx<=0, rk_valid<=1, internal rcon<=8'h01. start while busy is ignored.
- Window holds the last NK words w[i-NK..i-1]. round_key for idx 0 is key_in[KEY_BITS-1 -: 128]; for KEY_BITS=256, idx 1 is key_in[127:0] with no computation.
- Advance only when rk_valid && rk_ready: compute next 4 words, shift window, rk_idx+1. No advance without ready; all outputs hold.
- Next-group rule (first new word w[i], i multiple of 4):
  - KEY_BITS=128, or 256 with i mod 8 = 0: w[i] = w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon_out=rcon; afterwards rcon <= xtime(rcon) = {rcon[6:0],0} ^ (rcon[7] ? 8'h1B : 0).
  - KEY_BITS=256 with i mod 8 = 4: w[i] = w[i-8] ^ SubWord(w[i-1]); rcon_out=8'h00; rcon unchanged.
  - Remaining three words: w[j] = w[j-NK] ^ w[j-1].
- rcon_out=8'h00 for idx 0 (and idx 1 at 256). AES-128 sequence for idx 1..10: 01,02,04,08,10,20,40,80,1B,36.
- Beat idx=NR accepted -> rk_valid<=0, busy<=0, done<=1 for one cycle, state IDLE. start in that same cycle is ignored; earliest accepted start is the next cycle.
- reset_n low at any time (mid-stream included) aborts immediately to reset values; no done pulse.

## Timing
- Start-to-first-valid: 1 cycle (start sampled at edge N, rk_valid=1 after edge N).
- Throughput: 1 round key per cycle with rk_ready held high; NR+1 consecutive beats; busy high NR+1 cycles.
- round_key, rk_idx, rcon_out are registered; key derivation is one S-box layer plus XORs per cycle, combinational from window to next window.
- rk_ready is a pure input; no combinational path from rk_ready to any output.

## Configuration
- AES_KEY_STORE_EN defined: each accepted beat also writes round_key into an internal (NR+1) x 128 register array at rk_idx; rd_key <= array[rd_addr] each cycle (1-cycle read latency; rd_addr > NR returns 0). Array cleared on reset. Serves decryption, which consumes keys in reverse order.
- Not defined: no array, rd_addr ignored, rd_key tied to 0.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx1 a0fafe1788542cb123a339392a6c7605 rcon 01; idx10 d014f9a8c9ee2589e13f0cc8b6630ca6 rcon 36; done 1 cycle after idx10 beat; 11 beats total.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> idx0/1 equal key halves, idx2 9ba354118e6925afa51a8b5f2067fcde rcon 01, idx3 rcon 00, idx14 fe4890d1e6188d0b046df344706c631e; 15 beats.
- Backpressure: drop rk_ready for 3 cycles at idx 4 -> round_key/rk_idx/rcon_out stable; final keys identical to no-stall run.
- start pulsed while busy with a different key -> ignored; stream completes with original key.
- reset_n low at idx 5 -> all outputs to reset values asynchronously; subsequent start reproduces full stream from idx 0.
- With AES_KEY_STORE_EN, after 128-bit run read rd_addr=10 -> rd_key d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; rd_addr=15 -> 0.
